jtcop_mcu_host: RTL

Main-CPU side of the i8751 security-MCU mailbox used by the Dec0/Dec1 boards. Latches 16-bit commands written by the 68000 and presents them to the MCU through port 0 as byte strobes. Raises the MCU INT1 request. Collects the MCU's 16-bit reply and exposes it, with handshake flags, on the main CPU bus. It sits between the main CPU address decoder (`sec` chip selects) and the MCU port wiring in the game top level.

---
 rtl/jtcop_mcu_host.sv | 126 ++++++++++++
 1 files changed

// File: rtl/jtcop_mcu_host.sv
// jtcop_mcu_host: main-CPU side of the Dec0/Dec1 i8751 security-MCU mailbox.
// Latches 68000 commands for the MCU (port 0 byte strobes), drives MCU INT1,
// and collects the 16-bit MCU reply with handshake flags on the CPU bus.
// Optional macro JTCOP_MCU_TIMEOUT_EN: synthesizes a 16'hFFFF reply after
// TOVAL cycles without an MCU answer, so games boot without MCU firmware.
module jtcop_mcu_host #(
  parameter int unsigned    TOW   = 16,
  parameter logic [TOW-1:0] TOVAL = 16'd40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic        sec_cs,
  input  logic        addr1,
  input  logic        rnw,
  input  logic [1:0]  dsn,
  input  logic [15:0] cpu_dout,
  output logic [15:0] sec_dout,
  input  logic [7:0]  p0_o,
  input  logic [7:0]  p2_o,
  output logic [7:0]  p0_i,
  output logic        mcu_intn,
  output logic        cmd_pend,
  output logic        rep_valid
);

  logic [15:0] cmd;
  logic [15:0] rep;
  logic        ovr;
  logic [7:4]  p2l;
  logic        acc_l;
  logic        acc;
  logic        wr_data;
  logic        wr_stat;
  logic        rd_data;
  logic        rd_stat;
  logic [7:4]  rise;
  logic        to_hit;

  // Decode a bus access once, on its first qualified cycle
  assign acc     = sec_cs & cpu_cen & ~acc_l;
  assign wr_data = acc & ~rnw & ~addr1;
  assign wr_stat = acc & ~rnw &  addr1;
  assign rd_data = acc &  rnw & ~addr1;
  assign rd_stat = acc &  rnw &  addr1;
  assign rise    = p2_o[7:4] & ~p2l;

`ifdef JTCOP_MCU_TIMEOUT_EN
  logic [TOW-1:0] to_cnt;
  logic           waiting;
  logic           unused_p2;

  // A genuine reply or a fresh command on the terminal cycle beats the timeout
  assign to_hit    = (cmd_pend | waiting) & (to_cnt == TOVAL - TOW'(1)) & ~wr_data & ~rise[7];
  assign unused_p2 = ^p2_o[2:0];

  // Reply-timeout counter, restarted by every command write
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      waiting <= 1'b0;
    end else begin
      if (wr_data || to_hit) to_cnt <= '0;
      else if (cmd_pend || waiting) to_cnt <= to_cnt + TOW'(1);
      if (wr_data) waiting <= 1'b1;
      else if (rise[7] || to_hit) waiting <= 1'b0;
    end
  end
`else
  logic unused_bits;

  assign to_hit      = 1'b0;
  assign unused_bits = ^{p2_o[2:0], TOVAL};
`endif

  // Mailbox registers: CPU bus side and MCU strobe side share one register set
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd       <= 16'd0;
      rep       <= 16'd0;
      ovr       <= 1'b0;
      p2l       <= 4'hF;
      acc_l     <= 1'b0;
      p0_i      <= 8'd0;
      mcu_intn  <= 1'b1;
      cmd_pend  <= 1'b0;
      rep_valid <= 1'b0;
      sec_dout  <= 16'd0;
    end else begin
      acc_l <= sec_cs & cpu_cen;
      p2l   <= p2_o[7:4];

      if (wr_data && !dsn[1]) cmd[15:8] <= cpu_dout[15:8];
      if (wr_data && !dsn[0]) cmd[7:0]  <= cpu_dout[7:0];

      // Low-byte read wins when both read strobes rise together
      if (rise[5]) p0_i <= cmd[7:0];
      else if (rise[4]) p0_i <= cmd[15:8];

      if (wr_data) cmd_pend <= 1'b1;
      else if (rise[5] || to_hit) cmd_pend <= 1'b0;

      if (wr_data && cmd_pend) ovr <= 1'b1;
      else if (wr_stat) ovr <= 1'b0;

      // MCU disabling its interrupt releases INT1 even against a new command
      if (!p2_o[3]) mcu_intn <= 1'b1;
      else if (wr_data) mcu_intn <= 1'b0;
      else if (to_hit) mcu_intn <= 1'b1;

      if (to_hit) begin
        rep <= 16'hFFFF;
      end else begin
        if (rise[6]) rep[7:0]  <= p0_o;
        if (rise[7]) rep[15:8] <= p0_o;
      end

      if (rise[7] || to_hit) rep_valid <= 1'b1;
      else if (rd_data) rep_valid <= 1'b0;

      if (rd_data) sec_dout <= rep;
      else if (rd_stat) sec_dout <= {13'd0, ovr, rep_valid, cmd_pend};
    end
  end

endmodule
